// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and default constants for the hazard scoreboard slice.
package hazard_scoreboard_pkg;

    localparam int SB_RA_W_DEF    = 4;
    localparam int SB_NRD_DEF     = 2;
    localparam int SB_NFWD_DEF    = 2;
    localparam int SB_MUL_LAT_DEF = 3;
    localparam int SB_FLUSH_N_DEF = 2;

    // Tracking entries carry addresses at this fixed width so that one
    // typedef serves every RA_W up to this value (narrower addresses are
    // zero-extended on capture and on compare).
    localparam int SB_ADDR_MAX = 8;

    typedef struct packed {
        logic                   valid;
        logic                   wr;
        logic [SB_ADDR_MAX-1:0] addr;
        logic                   load;
    } stage_t;

    localparam stage_t STAGE_EMPTY = '{
        valid: 1'b0,
        wr:    1'b0,
        addr:  {SB_ADDR_MAX{1'b0}},
        load:  1'b0
    };

    // Width of a down-counter able to hold max_val (never narrower than 1 bit).
    function automatic int ctr_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_match.sv
// Compares one read port against every tracked producer stage and picks the
// nearest (lowest-index) matching producer.
module sb_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int RA_W = SB_RA_W_DEF,
    parameter int NFWD = SB_NFWD_DEF
) (
    input  logic                        rd_en,
    input  logic [RA_W-1:0]             rd_addr,
    input  logic [NFWD-1:0]             stg_wr,
    input  logic [NFWD*SB_ADDR_MAX-1:0] stg_addr,
    output logic [NFWD-1:0]             match_vec,
    output logic [NFWD-1:0]             near_oh
);

    logic [SB_ADDR_MAX-1:0] rd_addr_ext_s;
    logic                   found_s;

    // Per-stage address match and first-hit selection scanning from stage 0.
    always_comb begin
        rd_addr_ext_s = SB_ADDR_MAX'(rd_addr);
        match_vec     = {NFWD{1'b0}};
        near_oh       = {NFWD{1'b0}};
        found_s       = 1'b0;
        for (int k = 0; k < NFWD; k++) begin
            match_vec[k] = rd_en & stg_wr[k]
                         & (stg_addr[k*SB_ADDR_MAX +: SB_ADDR_MAX] == rd_addr_ext_s)
                         & (rd_addr != {RA_W{1'b0}});
            if (match_vec[k] && !found_s) begin
                near_oh[k] = 1'b1;
                found_s    = 1'b1;
            end else begin
                near_oh[k] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard scoreboard: load-use stalls, multi-cycle multiply
// occupancy, post-branch flush window, sticky halt and bypass selection.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int RA_W    = SB_RA_W_DEF,
    parameter int NRD     = SB_NRD_DEF,
    parameter int NFWD    = SB_NFWD_DEF,
    parameter int MUL_LAT = SB_MUL_LAT_DEF,
    parameter int FLUSH_N = SB_FLUSH_N_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_vld,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*RA_W-1:0]  rd_addr,
    input  logic                 wr_en,
    input  logic [RA_W-1:0]      wr_addr,
    input  logic                 is_load,
    input  logic                 is_mul,
    input  logic                 is_hlt,
    input  logic                 flow_change,
    output logic                 stall_if,
    output logic                 bubble,
    output logic [NRD*NFWD-1:0]  byp_sel,
    output logic                 mul_busy,
    output logic                 halted
);

    localparam int MUL_CW = ctr_width(MUL_LAT - 1);
    localparam int FL_CW  = ctr_width(FLUSH_N);

    localparam logic [MUL_CW-1:0] MUL_ZERO = {MUL_CW{1'b0}};
    localparam logic [MUL_CW-1:0] MUL_ONE  = MUL_CW'(1'b1);
    localparam logic [MUL_CW-1:0] MUL_LOAD = MUL_CW'(MUL_LAT - 1);
    localparam logic [FL_CW-1:0]  FL_ZERO  = {FL_CW{1'b0}};
    localparam logic [FL_CW-1:0]  FL_ONE   = FL_CW'(1'b1);
    localparam logic [FL_CW-1:0]  FL_LOAD  = FL_CW'(FLUSH_N);

    stage_t                      stage_r [NFWD];
    logic [MUL_CW-1:0]           mul_cnt_r;
    logic                        mul_busy_r;
    logic [FL_CW-1:0]            fl_cnt_r;
    logic                        halted_r;
    logic [NRD*NFWD-1:0]         byp_sel_r;

    logic [NFWD-1:0]             stg_wr_s;
    logic [NFWD*SB_ADDR_MAX-1:0] stg_addr_s;
    logic [NRD*NFWD-1:0]         match_s;
    logic [NRD*NFWD-1:0]         near_s;
    logic [NRD*NFWD-1:0]         byp_nxt_s;
    logic                        load_use_s;
    logic                        flushing_s;
    logic                        lu_flush_s;
    logic                        issue_s;
    logic [MUL_CW-1:0]           mul_cnt_nxt_s;
    logic [FL_CW-1:0]            fl_cnt_nxt_s;
    stage_t                      new_entry_s;

    // Flatten the tracking array into the vectors the per-port comparators take.
    always_comb begin
        stg_wr_s   = {NFWD{1'b0}};
        stg_addr_s = {(NFWD*SB_ADDR_MAX){1'b0}};
        for (int k = 0; k < NFWD; k++) begin
            stg_wr_s[k]                                = stage_r[k].valid & stage_r[k].wr;
            stg_addr_s[k*SB_ADDR_MAX +: SB_ADDR_MAX]   = stage_r[k].addr;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_port
        sb_match #(
            .RA_W (RA_W),
            .NFWD (NFWD)
        ) u_match (
            .rd_en     (rd_en[p]),
            .rd_addr   (rd_addr[p*RA_W +: RA_W]),
            .stg_wr    (stg_wr_s),
            .stg_addr  (stg_addr_s),
            .match_vec (match_s[p*NFWD +: NFWD]),
            .near_oh   (near_s[p*NFWD +: NFWD])
        );
    end

    // Hazard resolution: priority-ordered stall/bubble and the issue decision.
    always_comb begin
        load_use_s = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            load_use_s = load_use_s | (id_vld & match_s[p*NFWD] & stage_r[0].load);
        end
        flushing_s = (fl_cnt_r != FL_ZERO);
        // A branch resolving together with a load-use kills the dependent
        // instruction instead of stalling it, so fetch keeps moving.
        lu_flush_s = flow_change & load_use_s;
        if (rst) begin
            stall_if = 1'b0;
            bubble   = 1'b0;
        end else if (flushing_s || lu_flush_s) begin
            stall_if = 1'b0;
            bubble   = 1'b1;
        end else if (halted_r || mul_busy_r || load_use_s) begin
            stall_if = 1'b1;
            bubble   = 1'b1;
        end else begin
            stall_if = 1'b0;
            bubble   = 1'b0;
        end
        issue_s = id_vld & ~stall_if & ~flushing_s & ~lu_flush_s & ~halted_r & ~rst;
    end

    // Next values of the multiply-occupancy and flush-window counters.
    always_comb begin
        if (flow_change) begin
            mul_cnt_nxt_s = MUL_ZERO;
        end else if (mul_busy_r) begin
            mul_cnt_nxt_s = mul_cnt_r - MUL_ONE;
        end else if (issue_s && is_mul) begin
            mul_cnt_nxt_s = MUL_LOAD;
        end else begin
            mul_cnt_nxt_s = MUL_ZERO;
        end
        if (flow_change) begin
            fl_cnt_nxt_s = FL_LOAD;
        end else if (flushing_s) begin
            fl_cnt_nxt_s = fl_cnt_r - FL_ONE;
        end else begin
            fl_cnt_nxt_s = FL_ZERO;
        end
    end

    // Entry entering ID_EX: the issuing instruction, or an empty slot.
    always_comb begin
        new_entry_s = STAGE_EMPTY;
        if (issue_s) begin
            new_entry_s.valid = 1'b1;
            new_entry_s.wr    = wr_en & (wr_addr != {RA_W{1'b0}});
            new_entry_s.addr  = SB_ADDR_MAX'(wr_addr);
            new_entry_s.load  = is_load;
        end else begin
            new_entry_s = STAGE_EMPTY;
        end
        // The nearest-producer one-hot is by construction inside the match set.
        byp_nxt_s = near_s & match_s;
    end

    // State update: counters, halt latch, tracking array and bypass selects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_cnt_r  <= MUL_ZERO;
            mul_busy_r <= 1'b0;
            fl_cnt_r   <= FL_ZERO;
            halted_r   <= 1'b0;
            byp_sel_r  <= {(NRD*NFWD){1'b0}};
            for (int k = 0; k < NFWD; k++) begin
                stage_r[k] <= STAGE_EMPTY;
            end
        end else begin
            mul_cnt_r  <= mul_cnt_nxt_s;
            mul_busy_r <= (mul_cnt_nxt_s != MUL_ZERO);
            fl_cnt_r   <= fl_cnt_nxt_s;
            halted_r   <= halted_r | (issue_s & is_hlt);
            if (!mul_busy_r) begin
                stage_r[0] <= new_entry_s;
                for (int k = 1; k < NFWD; k++) begin
                    stage_r[k] <= stage_r[k-1];
                end
                if (issue_s) begin
                    byp_sel_r <= byp_nxt_s;
                end else begin
                    byp_sel_r <= {(NRD*NFWD){1'b0}};
                end
            end else begin
                byp_sel_r <= byp_sel_r;
            end
        end
    end

    assign byp_sel  = byp_sel_r;
    assign mul_busy = mul_busy_r;
    assign halted   = halted_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_hazard_scoreboard;

    localparam int RA_W    = 4;
    localparam int NRD     = 2;
    localparam int NFWD    = 2;
    localparam int MUL_LAT = 3;
    localparam int FLUSH_N = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                id_vld;
    logic [NRD-1:0]      rd_en;
    logic [NRD*RA_W-1:0] rd_addr;
    logic                wr_en;
    logic [RA_W-1:0]     wr_addr;
    logic                is_load, is_mul, is_hlt, flow_change;
    logic                stall_if, bubble, mul_busy, halted;
    logic [NRD*NFWD-1:0] byp_sel;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .RA_W(RA_W), .NRD(NRD), .NFWD(NFWD), .MUL_LAT(MUL_LAT), .FLUSH_N(FLUSH_N)
    ) dut (
        .clk(clk), .rst(rst), .id_vld(id_vld), .rd_en(rd_en), .rd_addr(rd_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .is_load(is_load), .is_mul(is_mul),
        .is_hlt(is_hlt), .flow_change(flow_change), .stall_if(stall_if),
        .bubble(bubble), .byp_sel(byp_sel), .mul_busy(mul_busy), .halted(halted)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: recent producers (index 0 = newest), remaining busy/flush cycles, halt flag.
    int                  h_wr [NFWD];
    int                  h_addr [NFWD];
    int                  h_load [NFWD];
    int                  mul_left, flush_left;
    bit                  m_halted;
    logic [NRD*NFWD-1:0] m_byp;
    int                  n_wr [NFWD];
    int                  n_addr [NFWD];
    int                  n_load [NFWD];
    int                  n_mul, n_flush;
    bit                  n_halted;
    logic [NRD*NFWD-1:0] n_byp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NFWD; k++) begin
            h_wr[k] = 0; h_addr[k] = 0; h_load[k] = 0;
        end
        mul_left = 0; flush_left = 0; m_halted = 1'b0; m_byp = '0;
    endtask

    function automatic bit hit(input int p, input int k);
        int ra;
        ra = int'(rd_addr[p*RA_W +: RA_W]);
        return rd_en[p] && (h_wr[k] != 0) && (h_addr[k] == ra) && (ra != 0);
    endfunction

    // Check every output against the model, then work out the model's next state.
    task automatic eval();
        bit lu, lufl, fl, e_st, e_bu, e_issue, found;
        logic [NRD*NFWD-1:0] nb;
        #1;
        if (rst) model_reset();
        lu = 1'b0;
        if (id_vld) begin
            for (int p = 0; p < NRD; p++) begin
                if (hit(p, 0) && h_load[0] != 0) lu = 1'b1;
            end
        end
        fl   = (flush_left > 0);
        lufl = flow_change && lu;
        if (rst) begin
            e_st = 1'b0; e_bu = 1'b0;
        end else if (fl || lufl) begin
            e_st = 1'b0; e_bu = 1'b1;
        end else if (m_halted || mul_left > 0 || lu) begin
            e_st = 1'b1; e_bu = 1'b1;
        end else begin
            e_st = 1'b0; e_bu = 1'b0;
        end
        e_issue = !rst && id_vld && !e_st && !fl && !lufl && !m_halted;

        chk("stall_if", stall_if, e_st);
        chk("bubble", bubble, e_bu);
        chk("mul_busy", mul_busy, mul_left > 0);
        chk("halted", halted, m_halted);
        chk("byp_sel", byp_sel, m_byp);

        nb = '0;
        for (int p = 0; p < NRD; p++) begin
            found = 1'b0;
            for (int k = 0; k < NFWD; k++) begin
                if (!found && hit(p, k)) begin
                    nb[p*NFWD+k] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        if (mul_left == 0) begin
            for (int k = NFWD-1; k > 0; k--) begin
                n_wr[k] = h_wr[k-1]; n_addr[k] = h_addr[k-1]; n_load[k] = h_load[k-1];
            end
            n_wr[0]   = (e_issue && wr_en && wr_addr != 0) ? 1 : 0;
            n_addr[0] = e_issue ? int'(wr_addr) : 0;
            n_load[0] = (e_issue && is_load) ? 1 : 0;
            n_byp     = e_issue ? nb : '0;
        end else begin
            for (int k = 0; k < NFWD; k++) begin
                n_wr[k] = h_wr[k]; n_addr[k] = h_addr[k]; n_load[k] = h_load[k];
            end
            n_byp = m_byp;
        end
        if (flow_change)               n_mul = 0;
        else if (mul_left > 0)         n_mul = mul_left - 1;
        else if (e_issue && is_mul)    n_mul = MUL_LAT - 1;
        else                           n_mul = 0;
        if (flow_change)               n_flush = FLUSH_N;
        else if (flush_left > 0)       n_flush = flush_left - 1;
        else                           n_flush = 0;
        n_halted = m_halted || (e_issue && is_hlt);
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < NFWD; k++) begin
                h_wr[k] = n_wr[k]; h_addr[k] = n_addr[k]; h_load[k] = n_load[k];
            end
            mul_left = n_mul; flush_left = n_flush; m_halted = n_halted; m_byp = n_byp;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        id_vld = 1'b0; rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0;
        is_load = 1'b0; is_mul = 1'b0; is_hlt = 1'b0; flow_change = 1'b0;
    endtask

    task automatic ins(input int ra0, input int ra1, input logic [1:0] en, input int wa,
                       input logic we, input logic ld, input logic mul, input logic hlt);
        id_vld = 1'b1; rd_en = en; rd_addr = {RA_W'(ra1), RA_W'(ra0)};
        wr_en = we; wr_addr = RA_W'(wa); is_load = ld; is_mul = mul; is_hlt = hlt;
    endtask

    task automatic quiet(input int n);
        idle();
        for (int i = 0; i < n; i++) begin
            eval(); adv();
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        eval();
        chk("rst_stall", stall_if, 1'b0);
        chk("rst_bubble", bubble, 1'b0);
        chk("rst_mul_busy", mul_busy, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_byp", byp_sel, 4'b0000);
        adv();
        rst = 1'b0;
        quiet(2);

        // LW R3 ; ADD R4,R3,R5
        ins(0, 0, 2'b00, 3, 1'b1, 1'b1, 1'b0, 1'b0); eval(); chk("lw_nostall", stall_if, 1'b0); adv();
        ins(3, 5, 2'b11, 4, 1'b1, 1'b0, 1'b0, 1'b0); eval();
        chk("lu_stall", stall_if, 1'b1); chk("lu_bubble", bubble, 1'b1); adv();
        eval(); chk("lu_release", stall_if, 1'b0); adv();
        idle(); eval(); chk("lu_byp", byp_sel, 4'b0010); adv();
        quiet(2);

        // ADD R3 ; SUB R6,R3,R3 then the same through R0
        ins(0, 0, 2'b00, 3, 1'b1, 1'b0, 1'b0, 1'b0); eval(); adv();
        ins(3, 3, 2'b11, 6, 1'b1, 1'b0, 1'b0, 1'b0); eval(); chk("alu_nostall", stall_if, 1'b0); adv();
        idle(); eval(); chk("alu_byp", byp_sel, 4'b0101); adv();
        ins(0, 0, 2'b00, 0, 1'b1, 1'b0, 1'b0, 1'b0); eval(); adv();
        ins(0, 0, 2'b11, 6, 1'b1, 1'b0, 1'b0, 1'b0); eval(); chk("r0_nostall", stall_if, 1'b0); adv();
        idle(); eval(); chk("r0_byp", byp_sel, 4'b0000); adv();
        quiet(2);

        // MUL R2 ; ADD R7,R2,R1
        ins(0, 0, 2'b00, 2, 1'b1, 1'b0, 1'b1, 1'b0); eval(); chk("mul_issue", stall_if, 1'b0); adv();
        ins(2, 1, 2'b11, 7, 1'b1, 1'b0, 1'b0, 1'b0);
        eval(); chk("mul_busy_c1", mul_busy, 1'b1); chk("mul_stall_c1", stall_if, 1'b1); adv();
        eval(); chk("mul_busy_c2", mul_busy, 1'b1); chk("mul_stall_c2", stall_if, 1'b1); adv();
        eval(); chk("mul_busy_c3", mul_busy, 1'b0); chk("mul_issue_c3", stall_if, 1'b0); adv();
        idle(); eval(); chk("mul_byp", byp_sel, 4'b0001); adv();
        quiet(2);

        // Two back-to-back flow changes
        ins(1, 1, 2'b11, 5, 1'b1, 1'b0, 1'b0, 1'b0); flow_change = 1'b1;
        eval(); chk("fc_first_nobub", bubble, 1'b0); adv();
        eval(); chk("fc_bub1", bubble, 1'b1); chk("fc_stall1", stall_if, 1'b0); adv();
        flow_change = 1'b0;
        eval(); chk("fc_bub2", bubble, 1'b1); chk("fc_stall2", stall_if, 1'b0); adv();
        eval(); chk("fc_bub3", bubble, 1'b1); chk("fc_stall3", stall_if, 1'b0); adv();
        eval(); chk("fc_bub_end", bubble, 1'b0); adv();
        quiet(2);

        // Halt, then halt arriving inside a flush window
        ins(0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b0, 1'b1); eval(); chk("hlt_pre", halted, 1'b0); adv();
        for (int i = 0; i < 20; i++) begin
            ins(i % 4, (i + 1) % 4, 2'(i), i % 8, 1'b1, 1'b0, 1'b0, 1'b0);
            eval(); chk("hlt_stall", stall_if, 1'b1); chk("hlt_sticky", halted, 1'b1); adv();
        end
        idle(); rst = 1'b1; eval(); adv();
        rst = 1'b0; eval(); adv();
        flow_change = 1'b1; eval(); adv();
        flow_change = 1'b0; ins(0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        eval(); chk("hlt_flush_bub", bubble, 1'b1); adv();
        idle();
        for (int i = 0; i < 3; i++) begin
            eval(); chk("hlt_discarded", halted, 1'b0); adv();
        end

        // Reset in the middle of a multiply
        quiet(2);
        ins(0, 0, 2'b00, 2, 1'b1, 1'b0, 1'b1, 1'b0); eval(); adv();
        idle(); eval(); chk("rmul_busy", mul_busy, 1'b1); adv();
        rst = 1'b1; eval();
        chk("rmul_busy_clr", mul_busy, 1'b0); chk("rmul_stall", stall_if, 1'b0);
        chk("rmul_bubble", bubble, 1'b0); adv();
        rst = 1'b0; ins(3, 5, 2'b11, 4, 1'b1, 1'b0, 1'b0, 1'b0);
        eval(); chk("rmul_first_issue", stall_if, 1'b0); adv();
        idle(); eval(); chk("rmul_byp", byp_sel, 4'b0000); adv();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            int r;
            idle();
            if (m_halted && $urandom_range(0, 7) == 0) rst = 1'b1;
            else if ($urandom_range(0, 499) == 0)       rst = 1'b1;
            else                                        rst = 1'b0;
            if ($urandom_range(0, 9) < 8) begin
                r = int'($urandom_range(0, 99));
                ins(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                    (r < 20), (r >= 20 && r < 28), (r == 99));
            end
            flow_change = ($urandom_range(0, 15) == 0);
            eval();
            adv();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
